sprite_palette_lut: RTL
=======================

Name: sprite_palette_lut

Overview:
Parametrised, writable, pipelined colour-lookup table for sprite rendering. Maps a per-pixel palette index plus a bank select (e.g. white/black piece set) to an RGB triple. Also flags transparent pixels by colour-key compare and applies an optional saturating highlight tint for selected or hovered squares. It sits between the sprite ROM index output and the VGA colour mux. Its palette banks are reloadable at runtime from the game controller.

Parameters:
IDX_W, 4, palette index width; DEPTH = 2**IDX_W entries per bank
CH_W, 4, bits per colour channel; entry width = 3*CH_W
NUM_BANKS, 2, independent palettes; BANK_W = max(1, clog2(NUM_BANKS))
KEY_COLOR, {CH_W'hF, 0, CH_W'hF} (magenta), colour value treated as transparent
HL_ADD, 3, per-channel increment applied when highlight is requested

Ports:
Clk  in  1  system clock, all logic rising-edge
Reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  lookup request this cycle
in_index  in  IDX_W  palette index from sprite ROM
in_bank  in  BANK_W  bank select for this pixel
in_highlight  in  1  apply highlight tint to this pixel
wr_en  in  1  palette write strobe
wr_bank  in  BANK_W  bank to write
wr_addr  in  IDX_W  entry to write
wr_data  in  3*CH_W  {R,G,B} to store
out_valid  out  1  output pixel valid
red  out  CH_W  red channel
green  out  CH_W  green channel
blue  out  CH_W  blue channel
transparent  out  1  stored colour equals KEY_COLOR

Behaviour:
- Reset (Reset_n low, asynchronous): every bank loads DEFAULT_PALETTE from the package. out_valid, transparent, red, green and blue are all 0, and pipeline valids are 0. Release is synchronous to Clk through a 2-flop synchroniser on deassert only.
- Pipeline, fixed latency 2:
  - Stage 1 (edge N) registers in_valid, in_index, in_bank and in_highlight.
  - Stage 2 (edge N+1) reads bank[in_bank][in_index], computes transparent and the tint, and registers the outputs.
  - A request in cycle N appears on the outputs in cycle N+2.
- Throughput is one pixel per clock with no stall or backpressure.
- Outputs hold their previous value while out_valid=0; only out_valid drops.
- Write: on an edge with wr_en=1, bank[wr_bank][wr_addr] <= wr_data.
  - A lookup captured on the same edge as a write to the same entry returns the new data, because the array read happens in the following cycle.
  - A lookup already in stage 1 when the write lands also returns the new data.
- Out-of-range bank (NUM_BANKS not a power of two, bank >= NUM_BANKS): writes are ignored and lookups return 0 with transparent=0.
- Transparency: transparent = (stored entry == KEY_COLOR), compared on the stored colour, not the index.
  - Transparent pixels are never tinted; their raw stored colour is passed through.
- Highlight: when highlight is set and the pixel is not transparent, each channel = min(ch + HL_ADD, 2**CH_W-1). Compute at CH_W+1 bits, then saturate.
- Asserting Reset_n low mid-stream discards in-flight pixels immediately and reloads the defaults. This overwrites any runtime palette writes.
- wr_en and in_valid may be asserted in the same cycle, with no priority conflict.

Decomposition:
- Package sprite_palette_pkg holds:
  - the rgb_t struct of CH_W-wide channels;
  - the DEFAULT_PALETTE constant, a 16-entry table: AAA, F0F, 323, FFF, 909, 101, 444, EEE, B0B, 404, 666, 888, 303, E0E, CCC, 606;
  - KEY_COLOR_DEFAULT;
  - a sat_add function.
- One sub-module, palette_tint, is the combinational saturating highlight/transparency stage. It is instantiated once in stage 2.
- The palette storage is a register array, not inferred BRAM, because the reset reload requires it.

Test Plan:
1. Reset, then in_valid=1, bank0, index 3, highlight 0 → two cycles later out_valid=1, RGB=F,F,F, transparent=0.
2. Index 1, bank1, highlight 1 → RGB=F,0,F and transparent=1, untinted.
3. Index 0 with highlight 1 → RGB=D,D,D. Index 7 (EEE) with highlight 1 → F,F,F, saturated.
4. Write bank1 addr 2 = 0x4A2 on the same edge a lookup of bank1 idx2 is captured → output 4,A,2. Bank0 idx2 still returns 3,2,3.
5. Write bank0 addr 5 = 0xF0F, then look it up → transparent=1. Write addr 1 = 0x123, then look it up → transparent=0, RGB 1,2,3.
6. Back-to-back 8-pixel burst with one Reset_n low pulse mid-burst → outputs and out_valid drop to 0 at once. The post-reset lookup of the modified addr 2 returns the default 3,2,3.

Source files
------------

// File: rtl/sprite_palette_pkg.sv
// Shared types, default palette and saturation helper for the sprite palette LUT.
package sprite_palette_pkg;

  localparam int PAL_CH_W = 4;

  typedef struct packed {
    logic [PAL_CH_W-1:0] r;
    logic [PAL_CH_W-1:0] g;
    logic [PAL_CH_W-1:0] b;
  } rgb_t;

  // Magenta is the colour key for transparent sprite pixels.
  localparam rgb_t KEY_COLOR_DEFAULT = '{r: 4'hF, g: 4'h0, b: 4'hF};

  localparam rgb_t DEFAULT_PALETTE [16] = '{
    rgb_t'(12'hAAA), rgb_t'(12'hF0F), rgb_t'(12'h323), rgb_t'(12'hFFF),
    rgb_t'(12'h909), rgb_t'(12'h101), rgb_t'(12'h444), rgb_t'(12'hEEE),
    rgb_t'(12'hB0B), rgb_t'(12'h404), rgb_t'(12'h666), rgb_t'(12'h888),
    rgb_t'(12'h303), rgb_t'(12'hE0E), rgb_t'(12'hCCC), rgb_t'(12'h606)
  };

  // Adds with one bit of headroom, then clamps to the channel maximum.
  function automatic int unsigned sat_add(input int unsigned ch,
                                          input int unsigned add,
                                          input int unsigned width);
    int unsigned max_val;
    int unsigned sum;
    max_val = (32'd1 << width) - 32'd1;
    sum     = ch + add;
    return (sum > max_val) ? max_val : sum;
  endfunction

endpackage

// File: rtl/palette_tint.sv
// Combinational colour-key compare and saturating highlight tint.
module palette_tint
  import sprite_palette_pkg::*;
#(
  parameter int CH_W   = 4,
  parameter int HL_ADD = 3,
  parameter logic [3*CH_W-1:0] KEY_COLOR = (3*CH_W)'(KEY_COLOR_DEFAULT)
) (
  input  logic [3*CH_W-1:0] raw,
  input  logic              highlight,
  output logic [3*CH_W-1:0] color,
  output logic              transparent
);

  // Transparent pixels pass through untinted; others get a clamped per-channel lift.
  always_comb begin
    transparent = (raw == KEY_COLOR);
    color       = raw;
    if (highlight && !transparent) begin
      for (int c = 0; c < 3; c++) begin
        color[c*CH_W +: CH_W] =
          CH_W'(sat_add(32'(raw[c*CH_W +: CH_W]), 32'(HL_ADD), 32'(CH_W)));
      end
    end
  end

endmodule

// File: rtl/sprite_palette_lut.sv
// Writable, two-stage pipelined sprite colour lookup with transparency and highlight.
module sprite_palette_lut
  import sprite_palette_pkg::*;
#(
  parameter int IDX_W     = 4,
  parameter int CH_W      = 4,
  parameter int NUM_BANKS = 2,
  parameter logic [3*CH_W-1:0] KEY_COLOR = (3*CH_W)'(KEY_COLOR_DEFAULT),
  parameter int HL_ADD    = 3,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int DEPTH    = 2 ** IDX_W,
  localparam int ENTRY_W  = 3 * CH_W
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               in_valid,
  input  logic [IDX_W-1:0]   in_index,
  input  logic [BANK_W-1:0]  in_bank,
  input  logic               in_highlight,
  input  logic               wr_en,
  input  logic [BANK_W-1:0]  wr_bank,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic               out_valid,
  output logic [CH_W-1:0]    red,
  output logic [CH_W-1:0]    green,
  output logic [CH_W-1:0]    blue,
  output logic               transparent
);

  logic               rst_meta;
  logic               rst_sync_n;
  logic [ENTRY_W-1:0] palette [NUM_BANKS][DEPTH];

  logic               s1_valid;
  logic [IDX_W-1:0]   s1_index;
  logic [BANK_W-1:0]  s1_bank;
  logic               s1_highlight;

  logic               wr_ok;
  logic               rd_ok;
  logic [ENTRY_W-1:0] rd_raw;
  logic [ENTRY_W-1:0] tint_color;
  logic               tint_transparent;

  assign wr_ok = (int'(wr_bank) < NUM_BANKS);
  assign rd_ok = (int'(s1_bank) < NUM_BANKS);

  // Reset asserts immediately; release is retimed through two flops.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Palette storage: reloads defaults on reset, otherwise takes runtime writes.
  always_ff @(posedge Clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          palette[b][i] <= ENTRY_W'(DEFAULT_PALETTE[i % 16]);
        end
      end
    end else if (wr_en && wr_ok) begin
      palette[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Stage 1: capture the request.
  always_ff @(posedge Clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      s1_valid     <= 1'b0;
      s1_index     <= '0;
      s1_bank      <= '0;
      s1_highlight <= 1'b0;
    end else begin
      s1_valid     <= in_valid;
      s1_index     <= in_index;
      s1_bank      <= in_bank;
      s1_highlight <= in_highlight;
    end
  end

  // Array read, forwarding a write that lands on the same edge as stage 2 registers.
  always_comb begin
    rd_raw = '0;
    if (rd_ok) begin
      if (wr_en && wr_ok && (wr_bank == s1_bank) && (wr_addr == s1_index)) begin
        rd_raw = wr_data;
      end else begin
        rd_raw = palette[s1_bank][s1_index];
      end
    end
  end

  palette_tint #(
    .CH_W      (CH_W),
    .HL_ADD    (HL_ADD),
    .KEY_COLOR (KEY_COLOR)
  ) u_tint (
    .raw         (rd_raw),
    .highlight   (s1_highlight && rd_ok),
    .color       (tint_color),
    .transparent (tint_transparent)
  );

  // Stage 2: colour outputs update only on valid pixels and hold otherwise.
  always_ff @(posedge Clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      out_valid   <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      transparent <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        {red, green, blue} <= tint_color;
        transparent        <= tint_transparent;
      end
    end
  end

endmodule
